aes_round_sequencer: RTL and testbench

Iterative AES cipher controller. It accepts one 128-bit block with an encrypt/decrypt flag, then drives one Round stage (or RoundInverse stage) per cycle, reusing a single datapath across all rounds. It fetches round keys by index from an external expanded-key store and returns the result over a valid/ready handshake. It sits between the host block interface and the Round/RoundInverse datapath.

---
 rtl/aes_round_sequencer_pkg.sv | 83 ++++++++
 rtl/Round.sv | 38 +++
 rtl/RoundInverse.sv | 40 ++++
 rtl/aes_round_datapath.sv | 61 ++++++
 rtl/aes_round_sequencer.sv | 108 ++++++++++
 tb/tb_aes_round_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES types, sequencer state encoding and GF(2^8) helpers used by the round datapath.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

package aes_round_sequencer_pkg;

    localparam int KEY_IDX_BITS = 4;

    typedef logic [127:0]            state_t;
    typedef logic [127:0]            roundKey_t;
    typedef logic [KEY_IDX_BITS-1:0] keyIndex_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        logic [7:0] bb;
        acc = 8'h00;
        sh  = a;
        bb  = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) acc = acc ^ sh;
            sh = gf_xtime(sh);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        if (!inv) begin
            return {gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
                    a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
                    a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
                    gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
        end
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/Round.sv
// One forward AES round: SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module Round
    import aes_round_sequencer_pkg::*;
#(
    parameter int ROUND_NUM  = 1,
    parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
    input  logic         valid_i,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);

    localparam bit IS_FINAL = (ROUND_NUM == NUM_ROUNDS);

    logic [127:0] sub_shift;
    logic [127:0] mixed;

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
        assign sub_shift[127-8*gi -: 8] = sbox(state_i[127-8*SRC -: 8]);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign mixed[127-32*gi -: 32] = IS_FINAL ? sub_shift[127-32*gi -: 32]
                                                 : mix_column(sub_shift[127-32*gi -: 32], 1'b0);
    end

    assign state_o = valid_i ? (mixed ^ key_i) : '0;

endmodule

// File: rtl/RoundInverse.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped in the last round).
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module RoundInverse
    import aes_round_sequencer_pkg::*;
#(
    parameter int ROUND_NUM  = 1,
    parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
    input  logic         valid_i,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);

    localparam bit IS_FINAL = (ROUND_NUM == NUM_ROUNDS);

    logic [127:0] unsub;
    logic [127:0] keyed;
    logic [127:0] mixed;

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        assign unsub[127-8*gi -: 8] = inv_sbox(state_i[127-8*SRC -: 8]);
    end

    assign keyed = unsub ^ key_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign mixed[127-32*gi -: 32] = IS_FINAL ? keyed[127-32*gi -: 32]
                                                 : mix_column(keyed[127-32*gi -: 32], 1'b1);
    end

    assign state_o = valid_i ? mixed : '0;

endmodule

// File: rtl/aes_round_datapath.sv
// Shared combinational round datapath: middle and last-round variants in both directions.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module aes_round_datapath
    import aes_round_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
    input  logic         valid_i,
    input  logic         mode_i,
    input  logic         is_final_i,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);

    logic [127:0] enc_mid;
    logic [127:0] enc_last;
    logic [127:0] dec_mid;
    logic [127:0] dec_last;

    Round #(.ROUND_NUM(1), .NUM_ROUNDS(NUM_ROUNDS)) u_enc_mid (
        .valid_i (valid_i && !mode_i && !is_final_i),
        .state_i (state_i),
        .key_i   (key_i),
        .state_o (enc_mid)
    );

    Round #(.ROUND_NUM(NUM_ROUNDS), .NUM_ROUNDS(NUM_ROUNDS)) u_enc_last (
        .valid_i (valid_i && !mode_i && is_final_i),
        .state_i (state_i),
        .key_i   (key_i),
        .state_o (enc_last)
    );

    RoundInverse #(.ROUND_NUM(1), .NUM_ROUNDS(NUM_ROUNDS)) u_dec_mid (
        .valid_i (valid_i && mode_i && !is_final_i),
        .state_i (state_i),
        .key_i   (key_i),
        .state_o (dec_mid)
    );

    RoundInverse #(.ROUND_NUM(NUM_ROUNDS), .NUM_ROUNDS(NUM_ROUNDS)) u_dec_last (
        .valid_i (valid_i && mode_i && is_final_i),
        .state_i (state_i),
        .key_i   (key_i),
        .state_o (dec_last)
    );

    always_comb begin
        case ({mode_i, is_final_i})
            2'b00:   state_o = enc_mid;
            2'b01:   state_o = enc_last;
            2'b10:   state_o = dec_mid;
            default: state_o = dec_last;
        endcase
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: accepts a block, runs one round per cycle through a shared
// datapath while fetching round keys by index, then holds the result until consumed.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module aes_round_sequencer
    import aes_round_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = `NUM_ROUNDS,
    parameter int KEY_IDX_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [127:0]         inData,
    input  logic                 inDecrypt,
    output logic [KEY_IDX_W-1:0] keyIndex,
    input  logic [127:0]         roundKey,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [127:0]         outData,
    output logic                 busy
);

    localparam int                   RND_W    = $clog2(NUM_ROUNDS + 1);
    localparam logic [KEY_IDX_W-1:0] LAST_KEY = KEY_IDX_W'(NUM_ROUNDS);
    localparam logic [RND_W-1:0]     LAST_MID = RND_W'(NUM_ROUNDS - 1);

    seqState_t          state_q, state_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [127:0]       data_q, data_d;
    logic               mode_q, mode_d;

    logic               accept;
    logic               dp_valid;
    logic               dp_final;
    logic [127:0]       dp_out;

    assign accept   = inValid && inReady;
    assign dp_valid = (state_q == ROUND) || (state_q == FINAL);
    assign dp_final = (state_q == FINAL);

    aes_round_datapath #(.NUM_ROUNDS(NUM_ROUNDS)) u_datapath (
        .valid_i    (dp_valid),
        .mode_i     (mode_q),
        .is_final_i (dp_final),
        .state_i    (data_q),
        .key_i      (roundKey),
        .state_o    (dp_out)
    );

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        data_d   = data_q;
        mode_d   = mode_q;
        keyIndex = '0;
        case (state_q)
            IDLE: begin
                keyIndex = inDecrypt ? LAST_KEY : '0;
                if (accept) begin
                    data_d  = inData ^ roundKey;
                    mode_d  = inDecrypt;
                    round_d = RND_W'(1);
                    state_d = (NUM_ROUNDS == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                // Decryption walks the key schedule backwards
                keyIndex = mode_q ? (LAST_KEY - KEY_IDX_W'(round_q)) : KEY_IDX_W'(round_q);
                data_d   = dp_out;
                round_d  = round_q + RND_W'(1);
                if (round_q == LAST_MID) state_d = FINAL;
            end
            FINAL: begin
                keyIndex = mode_q ? '0 : LAST_KEY;
                data_d   = dp_out;
                state_d  = DONE;
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign outValid = (state_q == DONE);
    assign outData  = data_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: known-answer table, handshake corner cases and random blocks
// compared against a byte-level AES reference model with its own key schedule.
module tb_aes_round_sequencer;

    localparam int NR = 10;

    typedef struct {
        logic [127:0] key;
        logic [127:0] din;
        logic         dec;
        logic [127:0] dout;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [127:0] inData;
    logic         inDecrypt;
    logic [3:0]   keyIndex;
    logic [127:0] roundKey;
    logic         outValid;
    logic         outReady;
    logic [127:0] outData;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk  [11];

    always #5 clock = ~clock;

    // Expanded-key store answers combinationally
    assign roundKey = (keyIndex <= 4'd10) ? rk[keyIndex] : 128'h0;

    aes_round_sequencer #(.NUM_ROUNDS(NR), .KEY_IDX_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .inDecrypt (inDecrypt),
        .keyIndex  (keyIndex),
        .roundKey  (roundKey),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] bb;
        r = 8'h00; x = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) r = r ^ x;
            x = xt(x);
            bb = bb >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Walk generator 3 and its inverse together to fill the S-box tables
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01; q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
    endtask

    task automatic load_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isb[gb(s, i)] : sb[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4 * src);
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - i + 4) % 4], gb(s, 4*c + j));
                o[127-8*(4*c+i) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] model_cipher(input logic [127:0] blk, input bit dec);
        logic [127:0] s;
        if (!dec) begin
            s = blk ^ rk[0];
            for (int r = 1; r <= NR; r++) begin
                s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
                if (r < NR) s = mix_cols(s, 1'b0);
                s = s ^ rk[r];
            end
        end else begin
            s = blk ^ rk[NR];
            for (int r = NR - 1; r >= 0; r--) begin
                s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
                s = s ^ rk[r];
                if (r > 0) s = mix_cols(s, 1'b1);
            end
        end
        return s;
    endfunction

    // ---------------- transaction driver ----------------
    task automatic run_block(input string name, input logic [127:0] din, input bit dec,
                             input logic [127:0] exp, input int bp, input bit scramble);
        logic [3:0]  kseq [$];
        logic [43:0] ks_act;
        logic [43:0] ks_exp;
        int          cyc;
        cyc = 0;
        while (!inReady && cyc < 50) begin @(posedge clock); #1; cyc++; end
        inValid = 1'b1; inData = din; inDecrypt = dec;
        #1;
        kseq.push_back(keyIndex);
        @(posedge clock); #1;
        inValid = 1'b0;
        if (scramble) begin
            inData    = {$urandom, $urandom, $urandom, $urandom};
            inDecrypt = ~dec;
        end
        cyc = 0;
        while (!outValid && cyc < 40) begin
            kseq.push_back(keyIndex);
            @(posedge clock); #1;
            cyc++;
        end
        check({name, "_latency"}, 160'(cyc), 160'(NR));
        ks_act = '0; ks_exp = '0;
        for (int i = 0; i <= NR; i++) begin
            ks_exp = {ks_exp[39:0], dec ? 4'(NR - i) : 4'(i)};
            ks_act = {ks_act[39:0], (i < kseq.size()) ? kseq[i] : 4'hf};
        end
        check({name, "_keyseq"}, 160'(ks_act), 160'(ks_exp));
        check({name, "_result"}, 160'({outValid, busy, inReady, outData}), 160'({3'b110, exp}));
        for (int i = 0; i < bp; i++) begin
            inValid = (i == 1);
            inData  = ~din;
            @(posedge clock); #1;
            check({name, "_hold"}, 160'({outValid, inReady, outData}), 160'({2'b10, exp}));
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clock); #1;
        outReady = 1'b0;
        check({name, "_release"}, 160'({outValid, inReady, busy}), 160'(3'b010));
        $display("txn %s: dec=%0d in=%h out=%h exp=%h lat=%0d bp=%0d", name, dec, din, outData, exp, cyc, bp);
    endtask

    vec_t vecs [4];

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] key, din, exp;
        bit           dec;
        int           e, acc;
        bit           got_a;

        build_sbox();
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1,
                    128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 1'b0,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1,
                    128'h3243f6a8885a308d313198a2e0370734};

        reset = 1'b1; inValid = 1'b0; inData = '0; inDecrypt = 1'b0; outReady = 1'b0;
        for (int r = 0; r < 11; r++) rk[r] = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", 160'({inReady, outValid, busy, keyIndex, outData}),
              160'({3'b100, 4'h0, 128'h0}));
        reset = 1'b0;

        // Known-answer table; first entry exercises backpressure, second an input change while busy
        for (int i = 0; i < 4; i++) begin
            load_key(vecs[i].key);
            check($sformatf("kat%0d_model", i), 160'(model_cipher(vecs[i].din, vecs[i].dec)), 160'(vecs[i].dout));
            run_block($sformatf("kat%0d", i), vecs[i].din, vecs[i].dec, vecs[i].dout,
                      (i == 0) ? 5 : 0, (i == 1));
        end

        // Back-to-back: encrypt then decrypt with inValid and outReady held high
        load_key(vecs[0].key);
        outReady = 1'b1; inValid = 1'b1; inData = vecs[0].din; inDecrypt = 1'b0;
        @(posedge clock); #1;
        inData = vecs[1].din; inDecrypt = 1'b1;
        e = 0; acc = 0; got_a = 1'b0;
        while (acc == 0 && e < 40) begin
            @(posedge clock); #1;
            e++;
            if (outValid && !got_a) begin
                got_a = 1'b1;
                check("b2b_first_edge", 160'(e), 160'(NR));
                check("b2b_first_data", 160'(outData), 160'(vecs[0].dout));
            end
            if (inReady) acc = e + 1;
        end
        check("b2b_first_seen", 160'(got_a), 160'(1));
        check("b2b_second_accept_edge", 160'(acc), 160'(NR + 2));
        @(posedge clock); #1;
        inValid = 1'b0;
        check("b2b_second_taken", 160'({inReady, busy}), 160'(2'b01));
        e = 0;
        while (!outValid && e < 40) begin @(posedge clock); #1; e++; end
        check("b2b_second_latency", 160'(e), 160'(NR));
        check("b2b_second_data", 160'(outData), 160'(vecs[1].dout));
        $display("txn b2b: first=%h second=%h", vecs[0].dout, outData);
        @(posedge clock); #1;
        check("b2b_drain", 160'({outValid, inReady}), 160'(2'b01));
        outReady = 1'b0;

        // Reset at edge 5 of an encrypt discards the block
        inValid = 1'b1; inData = vecs[0].din; inDecrypt = 1'b0;
        @(posedge clock); #1;
        inValid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midreset_state", 160'({inReady, outValid, busy, keyIndex, outData}),
              160'({3'b100, 4'h0, 128'h0}));
        $display("txn midreset: inReady=%0d outValid=%0d outData=%h", inReady, outValid, outData);
        reset = 1'b0;
        run_block("after_reset", vecs[0].din, 1'b0, vecs[0].dout, 0, 1'b0);

        // Random keys, blocks and directions against the model
        for (int n = 0; n < 12; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            din = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            load_key(key);
            exp = model_cipher(din, dec);
            run_block($sformatf("rand%0d", n), din, dec, exp, $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
